lsu_mw: RTL and testbench

- Load/store unit in the MW stage; consumes the registered memory controls (rd_en_MW, wr_en_MW, size_MW) and drives the data-memory bus.
- Drives a multi-cycle req/gnt/rvalid bus, stalls the pipeline until each access completes, and returns an aligned, extended load word to writeback.
- Flags misaligned accesses and bus timeouts.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_mw_load_extend.sv | 24 ++
 rtl/lsu_mw.sv | 135 +++++++++++++
 tb/tb_lsu_mw.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MW-stage load/store unit.
// Access-size codes follow funct3; byte enables derive from size and address low bits.
package lsu_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } access_size_e;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } lsu_state_e;

    typedef enum logic [1:0] {
        WidthByte,
        WidthHalf,
        WidthWord
    } access_width_e;

    // Unlisted funct3 codes fall back to a full word access.
    function automatic access_width_e width_of(input logic [2:0] size);
        access_width_e w;
        case (size)
            SZ_B, SZ_BU: w = WidthByte;
            SZ_H, SZ_HU: w = WidthHalf;
            default:     w = WidthWord;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (width_of(size))
            WidthByte: be = 4'b0001 << addr_lo;
            WidthHalf: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_mw_load_extend.sv
// Moves the addressed byte/half of a read word down to bit 0 and sign- or zero-extends it.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic        zext;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        zext    = (size == SZ_BU) || (size == SZ_HU);
        case (width_of(size))
            WidthByte: result = {{24{~zext & shifted[7]}}, shifted[7:0]};
            WidthHalf: result = {{16{~zext & shifted[15]}}, shifted[15:0]};
            default:   result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mw.sv
// MW-stage load/store unit: drives a req/gnt/rvalid data bus, stalls until the access
// completes or times out, and flags misaligned accesses without touching the bus.
module lsu_mw
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_en_MW,
    input  logic        wr_en_MW,
    input  logic [2:0]  size_MW,
    input  logic [31:0] addr_MW,
    input  logic [31:0] wdata_MW,
    output logic [31:0] load_data,
    output logic        done,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Abort on the last REQ/WAIT cycle, so the count reads TIMEOUT-1 in DONE.
    localparam logic [CntW-1:0] AbortCnt = CntW'(TIMEOUT - 2);

    lsu_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [31:0]     load_data_q, load_data_d;

    logic            access;
    access_width_e   width;
    logic [31:0]     ext_data;
    logic [31:0]     wdata_lane;

    assign access = rd_en_MW | wr_en_MW;
    assign width  = width_of(size_MW);

    always_comb begin
        misaligned = 1'b0;
        if (access) begin
            misaligned = ((width == WidthHalf) && addr_MW[0]) ||
                         ((width == WidthWord) && (addr_MW[1:0] != 2'b00));
        end
    end

    load_extend u_load_extend (
        .rdata   (mem_rdata),
        .size    (size_MW),
        .addr_lo (addr_MW[1:0]),
        .result  (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        load_data_d = load_data_q;
        unique case (state_q)
            StIdle: begin
                if (access && !misaligned) begin
                    state_d = StReq;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StReq: begin
                cnt_d = cnt_q + CntW'(1);
                if (mem_gnt) begin
                    state_d = wr_en_MW ? StDone : StWait;
                end else if (cnt_q == AbortCnt) begin
                    state_d     = StDone;
                    err_d       = 1'b1;
                    load_data_d = '0;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (mem_rvalid) begin
                    state_d     = StDone;
                    load_data_d = ext_data;
                end else if (cnt_q == AbortCnt) begin
                    state_d     = StDone;
                    err_d       = 1'b1;
                    load_data_d = '0;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
        end
    end

    always_comb begin
        case (width)
            WidthByte: wdata_lane = {4{wdata_MW[7:0]}};
            WidthHalf: wdata_lane = {2{wdata_MW[15:0]}};
            default:   wdata_lane = wdata_MW;
        endcase
    end

    always_comb begin
        mem_req   = (state_q == StReq);
        mem_we    = mem_req & wr_en_MW;
        mem_addr  = mem_req ? {addr_MW[31:2], 2'b00} : 32'h0;
        mem_be    = mem_req ? be_gen(size_MW, addr_MW[1:0]) : 4'b0000;
        mem_wdata = (mem_req && wr_en_MW) ? wdata_lane : 32'h0;
        done      = (state_q == StDone);
        bus_err   = done & err_q;
        stall     = reset & access & ~misaligned & (state_q != StDone);
        load_data = load_data_q;
    end

endmodule

// File: tb/tb_lsu_mw.sv
// Self-checking bench for lsu_mw: directed cases plus randomized back-to-back accesses
// compared against an arithmetic reference model of loads, lanes and latencies.
module tb_lsu_mw;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd_en_MW, wr_en_MW;
    logic [2:0]  size_MW;
    logic [31:0] addr_MW, wdata_MW;
    logic [31:0] load_data;
    logic        done, stall, misaligned, bus_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    int          r_req_n, r_wait_n, r_stall_n;
    logic        r_done, r_err, r_stall_idle, r_done_stall, r_we;
    logic [31:0] r_ld, r_wd, r_addr;
    logic [3:0]  r_be;

    always #5 clk = ~clk;

    lsu_mw #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en_MW   (rd_en_MW),
        .wr_en_MW   (wr_en_MW),
        .size_MW    (size_MW),
        .addr_MW    (addr_MW),
        .wdata_MW   (wdata_MW),
        .load_data  (load_data),
        .done       (done),
        .stall      (stall),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    function automatic int width_bytes(input logic [2:0] sz);
        if (sz == 3'd0 || sz == 3'd4) return 1;
        if (sz == 3'd1 || sz == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [2:0] sz,
                                               input int off);
        logic [31:0] v;
        int n;
        n = width_bytes(sz);
        v = rdata >> (8 * off);
        if (n == 4) return v;
        v = v % (32'd1 << (8 * n));
        if ((sz == 3'd0 || sz == 3'd1) && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] sz, input int off);
        int n;
        n = width_bytes(sz);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] sz, input logic [31:0] wd);
        int n;
        n = width_bytes(sz);
        if (n == 1) return (wd & 32'hFF) * 32'h01010101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    // Presents one access starting in IDLE and plays the bus side until done or a bound.
    // gnt_dly/rv_dly: cycles withheld before gnt/rvalid; negative means never.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] sz,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
        logic granted, gnt_now;
        rd_en_MW = rd; wr_en_MW = wr; size_MW = sz; addr_MW = addr; wdata_MW = wd;
        #1;
        r_stall_idle = stall;
        r_req_n = 0; r_wait_n = 0; r_stall_n = 0; r_done = 1'b0; r_err = 1'b0;
        r_ld = 32'h0; r_done_stall = 1'b1;
        r_be = 4'h0; r_wd = 32'h0; r_addr = 32'h0; r_we = 1'b0;
        granted = 1'b0;
        for (int c = 0; c < 40 && !r_done; c++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (done) begin
                r_done = 1'b1; r_ld = load_data; r_err = bus_err; r_done_stall = stall;
            end else if (mem_req) begin
                if (r_req_n == 0) begin
                    r_be = mem_be; r_wd = mem_wdata; r_addr = mem_addr; r_we = mem_we;
                end
                r_req_n++;
                if (stall) r_stall_n++;
                if (gnt_dly >= 0 && r_req_n > gnt_dly) mem_gnt = 1'b1;
                mem_rvalid = 1'($urandom_range(0, 1));
            end else if (granted) begin
                r_wait_n++;
                if (stall) r_stall_n++;
                mem_gnt = 1'($urandom_range(0, 1));
                if (rv_dly >= 0 && r_wait_n > rv_dly) begin
                    mem_rvalid = 1'b1; mem_rdata = rdata;
                end
            end
            gnt_now = mem_req & mem_gnt & ~wr;
            @(posedge clk);
            granted = granted | gnt_now;
            #2;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic idle_inputs();
        rd_en_MW = 1'b0; wr_en_MW = 1'b0; size_MW = 3'd0; addr_MW = 32'h0; wdata_MW = 32'h0;
    endtask

    task automatic test_reset();
        rd_en_MW = 1'b1; size_MW = 3'd2; addr_MW = 32'h100;
        #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (done !== 1'b0 || bus_err !== 1'b0)
            $display("FAIL reset_done: got %b/%b want 0/0", done, bus_err); else n_pass++;
        n_checks++; if (load_data !== 32'h0)
            $display("FAIL reset_ld: got %h want 00000000", load_data); else n_pass++;
        idle_inputs();
        @(posedge clk); #2; reset = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_lw_basic();
        run_access(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        idle_inputs();
        n_checks++; if (r_done !== 1'b1) $display("FAIL lw_done: got %b want 1", r_done); else n_pass++;
        n_checks++; if (r_ld !== 32'hDEADBEEF) $display("FAIL lw_data: got %h want deadbeef", r_ld); else n_pass++;
        n_checks++; if (r_addr !== 32'h100) $display("FAIL lw_addr: got %h want 00000100", r_addr); else n_pass++;
        n_checks++; if (r_stall_n !== 2) $display("FAIL lw_stall_cycles: got %0d want 2", r_stall_n); else n_pass++;
        n_checks++; if (r_stall_idle !== 1'b1) $display("FAIL lw_stall_accept: got %b want 1", r_stall_idle); else n_pass++;
        n_checks++; if (r_done_stall !== 1'b0 || r_err !== 1'b0)
            $display("FAIL lw_done_flags: got stall=%b err=%b want 0/0", r_done_stall, r_err); else n_pass++;
    endtask

    task automatic test_load_extend();
        run_access(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 1, 1);
        n_checks++; if (r_ld !== 32'hFFFFFF80) $display("FAIL lb_ext: got %h want ffffff80", r_ld); else n_pass++;
        run_access(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF1234, 0, 2);
        n_checks++; if (r_ld !== 32'h00000080) $display("FAIL lbu_ext: got %h want 00000080", r_ld); else n_pass++;
        run_access(1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF1234, 2, 0);
        n_checks++; if (r_ld !== 32'hFFFF80FF) $display("FAIL lh_ext: got %h want ffff80ff", r_ld); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_store();
        run_access(1'b0, 1'b1, 3'd0, 32'h201, 32'h000000A5, 32'h0, 0, 0);
        idle_inputs();
        n_checks++; if (r_be !== 4'b0010) $display("FAIL sb_be: got %b want 0010", r_be); else n_pass++;
        n_checks++; if (r_wd !== 32'hA5A5A5A5) $display("FAIL sb_wdata: got %h want a5a5a5a5", r_wd); else n_pass++;
        n_checks++; if (r_we !== 1'b1) $display("FAIL sb_we: got %b want 1", r_we); else n_pass++;
        n_checks++; if (r_done !== 1'b1 || r_wait_n !== 0 || r_stall_n !== 1)
            $display("FAIL sb_latency: got done=%b wait=%0d stall=%0d want 1/0/1",
                     r_done, r_wait_n, r_stall_n); else n_pass++;
    endtask

    task automatic test_misaligned();
        logic saw_bus;
        rd_en_MW = 1'b1; size_MW = 3'd2; addr_MW = 32'h102;
        #1;
        n_checks++; if (misaligned !== 1'b1) $display("FAIL lw_mis_flag: got %b want 1", misaligned); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL lw_mis_stall: got %b want 0", stall); else n_pass++;
        saw_bus = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mem_req || done) saw_bus = 1'b1;
            @(posedge clk); #2;
        end
        n_checks++; if (saw_bus !== 1'b0) $display("FAIL lw_mis_nobus: got %b want 0", saw_bus); else n_pass++;
        idle_inputs();
        wr_en_MW = 1'b1; size_MW = 3'd1; addr_MW = 32'h203;
        #1;
        n_checks++; if (misaligned !== 1'b1) $display("FAIL sh_mis_flag: got %b want 1", misaligned); else n_pass++;
        idle_inputs();
        @(posedge clk); #2;
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 32'h12345678, -1, 0);
        n_checks++; if (r_req_n !== 15) $display("FAIL to_req_cycles: got %0d want 15", r_req_n); else n_pass++;
        n_checks++; if (r_done !== 1'b1 || r_err !== 1'b1)
            $display("FAIL to_err: got done=%b err=%b want 1/1", r_done, r_err); else n_pass++;
        n_checks++; if (r_ld !== 32'h0 || r_done_stall !== 1'b0)
            $display("FAIL to_done_state: got ld=%h stall=%b want 0/0", r_ld, r_done_stall); else n_pass++;
        run_access(1'b1, 1'b0, 3'd2, 32'h404, 32'h0, 32'h12345678, 2, -1);
        n_checks++; if (r_req_n + r_wait_n !== 15 || r_err !== 1'b1)
            $display("FAIL to_wait: got cycles=%0d err=%b want 15/1", r_req_n + r_wait_n, r_err); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic rd, wr;
        logic [2:0] sz;
        logic [31:0] addr, wd, rdata;
        int gd, rv, n, exp_stall;
        for (int k = 0; k < 30; k++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            sz = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            n = width_bytes(sz);
            addr = $urandom & ~(32'(n) - 32'd1);
            wd = $urandom; rdata = $urandom;
            gd = $urandom_range(0, 5); rv = $urandom_range(0, 5);
            exp_stall = (gd + 1) + (wr ? 0 : rv + 1);
            run_access(rd, wr, sz, addr, wd, rdata, gd, rv);
            n_checks++; if (r_done !== 1'b1 || r_err !== 1'b0)
                $display("FAIL b2b_done[%0d]: got done=%b err=%b want 1/0", k, r_done, r_err); else n_pass++;
            n_checks++; if (r_stall_n !== exp_stall)
                $display("FAIL b2b_stall[%0d]: got %0d want %0d", k, r_stall_n, exp_stall); else n_pass++;
            n_checks++; if (r_addr !== (addr & ~32'h3) || r_be !== model_be(sz, int'(addr % 4)) || r_we !== wr)
                $display("FAIL b2b_bus[%0d]: got addr=%h be=%b we=%b want %h/%b/%b", k, r_addr, r_be,
                         r_we, addr & ~32'h3, model_be(sz, int'(addr % 4)), wr); else n_pass++;
            if (wr) begin
                n_checks++; if (r_wd !== model_wdata(sz, wd))
                    $display("FAIL b2b_wdata[%0d]: got %h want %h", k, r_wd, model_wdata(sz, wd)); else n_pass++;
            end else begin
                n_checks++; if (r_ld !== model_load(rdata, sz, int'(addr % 4)))
                    $display("FAIL b2b_load[%0d]: got %h want %h", k, r_ld,
                             model_load(rdata, sz, int'(addr % 4))); else n_pass++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_access();
        logic saw_done;
        rd_en_MW = 1'b1; size_MW = 3'd2; addr_MW = 32'h300;
        @(posedge clk); #2;
        mem_gnt = 1'b1;
        @(posedge clk); #2;
        mem_gnt = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0)
            $display("FAIL rst_mid_outs: got stall=%b req=%b done=%b want 0/0/0", stall, mem_req, done); else n_pass++;
        n_checks++; if (load_data !== 32'h0) $display("FAIL rst_mid_ld: got %h want 00000000", load_data); else n_pass++;
        idle_inputs();
        @(posedge clk); #2; reset = 1'b1;
        @(posedge clk); #2;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            mem_rvalid = 1'b0;
            if (done) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0 || load_data !== 32'h0)
            $display("FAIL rst_late_rvalid: got done=%b ld=%h want 0/00000000", saw_done, load_data); else n_pass++;
        run_access(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 32'h13579BDF, 0, 0);
        idle_inputs();
        n_checks++; if (r_done !== 1'b1 || r_ld !== 32'h13579BDF)
            $display("FAIL rst_after_lw: got done=%b ld=%h want 1/13579bdf", r_done, r_ld); else n_pass++;
    endtask

    initial begin
        idle_inputs();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        test_reset();
        test_lw_basic();
        test_load_extend();
        test_store();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
